// File: rtl/mem_link_master.sv
// Host-side initiator for the UART memory-access link: serialises one write or
// range-read command into header+frame bytes and reassembles returned read words.
module mem_link_master #(
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_hi,
   input  logic [3:0]            cmd_we,
   input  logic [31:0]           cmd_wdata,
   output logic [7:0]            tx_data,
   output logic                  tx_start,
   input  logic                  tx_done,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [31:0]           rd_data,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_valid,
   output logic                  done,
   output logic                  err
);

   // state  | meaning
   // IDLE   | waiting for a command, cmd_ready high
   // SEND   | one frame byte in flight, waiting for tx_done
   // RECV   | collecting read response bytes, timeout armed
   // LAST   | last word emitted, done pulses next cycle
   // DONE   | one-cycle tail before returning to IDLE
   typedef enum logic [2:0] {S_IDLE, S_SEND, S_RECV, S_LAST, S_DONE} state_t;

   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t                state;
   logic                  c_write;
   logic [ADDR_WIDTH-1:0] c_addr;
   logic [ADDR_WIDTH-1:0] c_hi;
   logic [3:0]            c_we;
   logic [31:0]           c_wdata;
   logic [2:0]            idx;
   logic [31:0]           asm_word;
   logic [1:0]            byte_cnt;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [14:0]           words_left;
   logic [31:0]           tmo_cnt;

   logic                  rd_bad;
   logic [ADDR_WIDTH-1:0] span;
   logic [14:0]           word_count;
   logic [2:0]            last_idx;

   assign rd_bad     = (cmd_addr[1:0] != 2'b00) || (cmd_addr_hi[1:0] != 2'b00) ||
                       (cmd_addr_hi < cmd_addr);
   assign span       = cmd_addr_hi - cmd_addr;
   assign word_count = 15'((span >> 2) + 16'd1);
   assign last_idx   = c_write ? 3'd7 : 3'd4;
   assign cmd_ready  = (state == S_IDLE);

   function automatic logic [7:0] frame_byte(
      input logic                  wr,
      input logic [2:0]            i,
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [ADDR_WIDTH-1:0] hi,
      input logic [3:0]            we,
      input logic [31:0]           wdata
   );
      logic [7:0] b;
      b = 8'h00;
      if (wr) begin
         case (i)
            3'd0: b = 8'h0F;
            3'd1: b = addr[7:0];
            3'd2: b = addr[15:8];
            3'd3: b = {4'b0000, we};
            3'd4: b = wdata[7:0];
            3'd5: b = wdata[15:8];
            3'd6: b = wdata[23:16];
            3'd7: b = wdata[31:24];
            default: b = 8'h00;
         endcase
      end else begin
         case (i)
            3'd0: b = 8'hFF;
            3'd1: b = hi[7:0];
            3'd2: b = hi[15:8];
            3'd3: b = addr[7:0];
            3'd4: b = addr[15:8];
            default: b = 8'h00;
         endcase
      end
      return b;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         c_write    <= 1'b0;
         c_addr     <= '0;
         c_hi       <= '0;
         c_we       <= 4'h0;
         c_wdata    <= 32'h0;
         idx        <= 3'd0;
         asm_word   <= 32'h0;
         byte_cnt   <= 2'd0;
         cur_addr   <= '0;
         words_left <= 15'd0;
         tmo_cnt    <= 32'd0;
         tx_data    <= 8'h00;
         tx_start   <= 1'b0;
         rd_data    <= 32'h0;
         rd_addr    <= '0;
         rd_valid   <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         rd_valid <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  c_write    <= cmd_write;
                  c_addr     <= cmd_addr;
                  c_hi       <= cmd_addr_hi;
                  c_we       <= cmd_we;
                  c_wdata    <= cmd_wdata;
                  idx        <= 3'd0;
                  asm_word   <= 32'h0;
                  byte_cnt   <= 2'd0;
                  cur_addr   <= cmd_addr;
                  words_left <= word_count;
                  if (!cmd_write && rd_bad) begin
                     err   <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     tx_start <= 1'b1;
                     tx_data  <= cmd_write ? 8'h0F : 8'hFF;
                     state    <= S_SEND;
                  end
               end
            end
            S_SEND: begin
               // tx_done coinciding with our own tx_start belongs to an older byte
               if (tx_done && !tx_start) begin
                  if (idx == last_idx) begin
                     if (c_write) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                     end else begin
                        tmo_cnt <= 32'd1;
                        state   <= S_RECV;
                     end
                  end else begin
                     idx      <= idx + 3'd1;
                     tx_start <= 1'b1;
                     tx_data  <= frame_byte(c_write, idx + 3'd1, c_addr, c_hi, c_we, c_wdata);
                  end
               end
            end
            S_RECV: begin
               if (rx_valid) begin
                  tmo_cnt  <= 32'd1;
                  asm_word <= {rx_data, asm_word[31:8]};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     rd_valid   <= 1'b1;
                     rd_data    <= {rx_data, asm_word[31:8]};
                     rd_addr    <= cur_addr;
                     cur_addr   <= cur_addr + 16'd4;
                     words_left <= words_left - 15'd1;
                     if (words_left == 15'd1) state <= S_LAST;
                  end
               end else if (tmo_cnt >= TMO_LAST) begin
                  err      <= 1'b1;
                  asm_word <= 32'h0;
                  byte_cnt <= 2'd0;
                  state    <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
               end
            end
            S_LAST: begin
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_link_master.md
# mem_link_master

Host-side initiator for the UART memory-access link. It takes one word-write or one range-read command from local logic and serialises it as a header byte plus a frame into the UART transmitter. For reads it collects the returned byte stream from the UART receiver and reassembles it into 32-bit words. It is used for FPGA-to-FPGA debug links and closed-loop verification of the target-side memory-access responder.

## Interface
Parameters:
- ADDR_WIDTH, 16, byte-address width carried in frames; fixed at 16 by the frame format.
- TIMEOUT_CYCLES, 1_000_000, maximum idle cycles between received read bytes before abort.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = word write, 0 = range read.
- cmd_addr  in  16  write address, or read low address (ADDR_LOW).
- cmd_addr_hi  in  16  read high address (ADDR_HIGH), inclusive; ignored for writes.
- cmd_we  in  4  byte write enables; ignored for reads.
- cmd_wdata  in  32  write data.
- tx_data  out  8  byte to the UART transmitter.
- tx_start  out  1  one-cycle pulse; tx_data is valid in that cycle.
- tx_done  in  1  one-cycle pulse from the transmitter when the byte has fully left.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle pulse; rx_data is valid in that cycle.
- rd_data  out  32  reassembled read word.
- rd_addr  out  16  address of rd_data.
- rd_valid  out  1  one-cycle pulse per read word.
- done  out  1  one-cycle pulse when the command completes successfully.
- err  out  1  one-cycle pulse on a rejected command or on timeout.

## Operation
- Frame formats. All multi-byte fields are sent LSB first.
  - Write: 8 bytes total: 0x0F, addr[7:0], addr[15:8], {4'b0, we}, wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24].
  - Read: 5 bytes total: 0xFF, hi[7:0], hi[15:8], lo[7:0], lo[15:8].
  - Read response: words lo, lo+4, …, hi, each 4 bytes LSB first.
  - Expected word count = ((hi−lo)>>2)+1, computed in 15 bits.
- Command capture: all cmd_* inputs are registered at acceptance. Later changes to cmd_* have no effect on the command in flight.
- Read rejection: a read with lo[1:0]≠0, hi[1:0]≠0, or hi<lo is rejected. The block pulses err in the cycle after acceptance, sends no bytes, and returns to IDLE.
- States:
  - IDLE: cmd_ready=1. On accept, go to SEND with byte index 0.
  - SEND: tx_start pulses for the current byte, then the block holds until tx_done. On tx_done, the index increments. After the last byte of a write, go to DONE. After the last byte of a read, go to RECV.
  - RECV: each rx_valid shifts rx_data into a 32-bit assembly register from the top, {rx_data, asm[31:8]}, and advances a 2-bit byte counter.
    - When the counter wraps 3→0, the word is emitted: rd_data=assembled word, rd_addr=current address. The address then increments by 4 and the remaining word count decrements.
    - When the last word is emitted, go to DONE.
  - DONE: pulse done, then go to IDLE.
- rx_valid outside RECV is ignored and discarded.
- tx_done outside SEND, or before the corresponding tx_start, is ignored.
- Timeout: a counter resets on entry to RECV and on every rx_valid. If it reaches TIMEOUT_CYCLES, the block pulses err, discards the partial word, and goes to IDLE.
- Reset, including mid-operation: next state is IDLE. All outputs reset as follows:
  - tx_data=0, tx_start=0, rd_data=0, rd_addr=0, rd_valid=0, done=0, err=0.
  - cmd_ready=1 from the first cycle after reset is released.
  - Internal counters and the assembly register are cleared.

## Timing
- The command is accepted at cycle T. The first tx_start (header byte) occurs at T+1.
- When tx_done arrives at cycle D for a non-final byte, the next tx_start occurs at D+1.
- Write: when tx_done for byte 7 arrives at cycle D, done pulses at D+1 and cmd_ready=1 at D+2.
- Read: the final request byte's tx_done at D moves the block to RECV at D+1. An rx_valid in cycle D+1 is captured.
- When the 4th rx_valid of a word arrives at cycle R, rd_valid and rd_data/rd_addr are registered at R+1. rd_data/rd_addr hold until the next rd_valid.
- For the last word, done pulses at R+2 and cmd_ready=1 at R+3.
- Back-to-back rx_valid pulses in consecutive cycles must be accepted without loss.
- Rejection: accepted at T, err pulses at T+1, cmd_ready=1 at T+2.

## Test plan
- Write 0x0100, we=0xF, wdata=0xDEADBEEF, with a tx model returning tx_done 10 cycles after each tx_start -> tx bytes 0F 00 01 0F EF BE AD DE, exactly 8 tx_start pulses, done at last tx_done+1.
- Read lo=0x0010, hi=0x0018, with the receiver driving 12 bytes 11 22 33 44 55 66 77 88 99 AA BB CC -> tx bytes FF 18 00 10 00, then rd_valid ×3 with the following (addr, data), then done once:
  - 0x0010, 0x44332211
  - 0x0014, 0x88776655
  - 0x0018, 0xCCBBAA99
- Read lo=hi=0x7FFC with 4 bytes sent on consecutive cycles -> single rd_valid with rd_addr=0x7FFC, no bytes lost.
- Read lo=0x0020, hi=0x0010, and separately lo=0x0002 -> err at T+1, zero tx_start pulses, cmd_ready back at T+2.
- Read expecting 2 words, only 5 bytes delivered, TIMEOUT_CYCLES=100 -> one rd_valid, err 100 cycles after the 5th byte, no done, returns to IDLE.
- rst asserted mid-SEND of a write, and stray rx_valid while in IDLE -> all outputs 0, cmd_ready=1 after release, and a subsequent write frame is sent correctly.
